// File: rtl/icache_axi_refill_bridge_pkg.sv
// Shared types and constants for the I-cache AXI refill bridge.
//   slot_state_e  : refill slot state (FREE / WAIT)
//   slot_flags_t  : per-slot request attributes tracked while waiting
//   AXI_BURST_*   : AR burst encodings
//   idx_width()   : width of an index into n items (at least 1 bit)
package icache_axi_refill_bridge_pkg;

  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_WAIT = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic nc;
    logic kill;
    logic err;
  } slot_flags_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  // RRESP[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  localparam int unsigned AXI_RESP_ERR_BIT = 1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_refill_slot.sv
// One refill slot: tracks a single outstanding AXI read burst and assembles
// its beats into a cache line.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   flush_i                 kill the refill if currently waiting
//   alloc_i                 slot is allocated to a new request this cycle
//   tid_i, nc_i, start_i    request attributes; start_i = first word of burst
//   beat_i                  an R beat for this slot's ID is accepted
//   beat_data_i/err_i/last_i  beat payload, RRESP[1], RLAST
//   free_o                  slot is FREE (registered)
//   done_o                  one-cycle completion pulse (not raised if killed)
//   tid_o, nc_o, err_o      attributes of the completed refill
//   line_o                  assembled line, word-ordered
//
// state     | meaning
// ----------+-------------------------------------------------
// SLOT_FREE | idle, may be allocated
// SLOT_WAIT | AR issued or pending, collecting R beats until RLAST
module icache_refill_slot
  import icache_axi_refill_bridge_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned TidWidth     = 2,
  localparam int unsigned Words       = LineWidth / AxiDataWidth,
  localparam int unsigned IdxW        = idx_width(Words)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    alloc_i,
  input  logic [TidWidth-1:0]     tid_i,
  input  logic                    nc_i,
  input  logic [IdxW-1:0]         start_i,
  input  logic                    beat_i,
  input  logic [AxiDataWidth-1:0] beat_data_i,
  input  logic                    beat_err_i,
  input  logic                    beat_last_i,
  output logic                    free_o,
  output logic                    done_o,
  output logic [TidWidth-1:0]     tid_o,
  output logic                    nc_o,
  output logic                    err_o,
  output logic [LineWidth-1:0]    line_o
);

  localparam int unsigned CntW = $clog2(Words + 1);

  slot_state_e           state_q, state_d;
  logic                  done_d, done_q;
  logic [TidWidth-1:0]   tid_q;
  slot_flags_t           flags_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       start_q;
  logic [IdxW-1:0]       widx;
  logic [CntW:0]         wsum;
  logic [LineWidth-1:0]  line_q;
  logic                  beat_live;
  logic                  room;

  assign beat_live = beat_i & (state_q == SLOT_WAIT);
  // Once a full line has arrived, further beats are a protocol error and
  // leave the buffer untouched.
  assign room      = (cnt_q < CntW'(Words));
  // Word index = (start + count) mod Words; both terms are < Words so one
  // conditional subtract suffices.
  assign wsum      = (CntW+1)'(start_q) + (CntW+1)'(cnt_q);
  assign widx      = (wsum >= (CntW+1)'(Words)) ? IdxW'(wsum - (CntW+1)'(Words))
                                                : IdxW'(wsum);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SLOT_FREE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      SLOT_FREE: if (alloc_i) state_d = SLOT_WAIT;
      SLOT_WAIT: begin
        if (beat_live && beat_last_i) begin
          state_d = SLOT_FREE;
          done_d  = !flags_q.kill && !flush_i;
        end
      end
      default: state_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q  <= 1'b0;
      tid_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      line_q  <= '0;
    end else begin
      done_q <= done_d;
      if (alloc_i && state_q == SLOT_FREE) begin
        tid_q   <= tid_i;
        flags_q <= '{nc: nc_i, kill: 1'b0, err: 1'b0};
        cnt_q   <= '0;
        start_q <= start_i;
        line_q  <= '0;
      end else if (state_q == SLOT_WAIT) begin
        if (flush_i) flags_q.kill <= 1'b1;
        if (beat_live) begin
          flags_q.err <= flags_q.err | beat_err_i;
          if (room) begin
            line_q[widx*AxiDataWidth +: AxiDataWidth] <= beat_data_i;
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign free_o = (state_q == SLOT_FREE);
  assign done_o = done_q;
  assign tid_o  = tid_q;
  assign nc_o   = flags_q.nc;
  assign err_o  = flags_q.err;
  assign line_o = line_q;

endmodule

// File: rtl/icache_axi_refill_bridge.sv
// I-cache refill bridge: L1I miss requests -> AXI4 AR/R, up to MaxOutstanding
// refills in flight, one slot per AXI ID, out-of-order line assembly.
// Optional build macro: ICACHE_REFILL_CRIT_WORD_EN (critical-word-first WRAP
// bursts for cacheable refills; line is still returned whole).
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   flush_i                           kill all in-flight refills
//   req_valid_i/ready_o, req_paddr_i, req_nc_i, req_tid_i   miss request
//   rtrn_valid_o, rtrn_data_o, rtrn_tid_o, rtrn_nc_o, rtrn_err_o  line return
//   ar_*                              AXI read address channel
//   r_*                               AXI read data channel
//   busy_o                            any refill pending or AR not yet taken
module icache_axi_refill_bridge
  import icache_axi_refill_bridge_pkg::*;
#(
  parameter int unsigned PaddrWidth     = 56,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned LineWidth      = 128,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PaddrWidth-1:0]   req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    rtrn_valid_o,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic                    rtrn_nc_o,
  output logic                    rtrn_err_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic [AxiIdWidth-1:0]   r_id_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i,
  output logic                    busy_o
);

  localparam int unsigned Words     = LineWidth / AxiDataWidth;
  localparam int unsigned IdxW      = idx_width(Words);
  localparam int unsigned WordBytes = AxiDataWidth / 8;
  localparam int unsigned LineBytes = LineWidth / 8;
  localparam int unsigned WordOffW  = $clog2(WordBytes);

  logic [MaxOutstanding-1:0] slot_free;
  logic [MaxOutstanding-1:0] slot_done;
  logic [MaxOutstanding-1:0] slot_nc;
  logic [MaxOutstanding-1:0] slot_err;
  logic [MaxOutstanding-1:0] alloc_vec;
  logic [MaxOutstanding-1:0] beat_vec;
  logic [TidWidth-1:0]       slot_tid  [MaxOutstanding];
  logic [LineWidth-1:0]      slot_line [MaxOutstanding];

  logic                    any_free;
  logic [AxiIdWidth-1:0]   alloc_idx;
  logic                    accept;
  logic                    r_hs;
  logic                    r_ready_q;

  logic                    ar_valid_q;
  logic [AxiAddrWidth-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]              ar_len_q, ar_len_d;
  logic [1:0]              ar_burst_q, ar_burst_d;
  logic [AxiIdWidth-1:0]   ar_id_q;
  logic [IdxW-1:0]         start_d;
  logic                    unused_resp;

  assign unused_resp = r_resp_i[0];

  // Lowest-index free slot wins. The free vector is registered, so a slot
  // freed by RLAST this cycle is only visible next cycle.
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    for (int s = 0; s < int'(MaxOutstanding); s++) begin
      if (slot_free[s] && !any_free) begin
        any_free  = 1'b1;
        alloc_idx = AxiIdWidth'(s);
      end
    end
  end

  assign req_ready_o = any_free & (~ar_valid_q | ar_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    ar_addr_d  = AxiAddrWidth'(req_paddr_i & ~PaddrWidth'(LineBytes - 1));
    ar_len_d   = 8'(Words - 1);
    ar_burst_d = AXI_BURST_INCR;
    start_d    = '0;
    if (req_nc_i) begin
      ar_addr_d = AxiAddrWidth'(req_paddr_i & ~PaddrWidth'(WordBytes - 1));
      ar_len_d  = 8'd0;
    end
`ifdef ICACHE_REFILL_CRIT_WORD_EN
    else if (Words > 1) begin
      ar_addr_d  = AxiAddrWidth'(req_paddr_i & ~PaddrWidth'(WordBytes - 1));
      ar_burst_d = AXI_BURST_WRAP;
      start_d    = IdxW'((req_paddr_i >> WordOffW) & PaddrWidth'(Words - 1));
    end
`endif
  end

  // AR payload holds until the handshake; a new accept may reload it in the
  // same cycle the previous address is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= '0;
      ar_id_q    <= '0;
      r_ready_q  <= 1'b0;
    end else begin
      r_ready_q <= 1'b1;
      if (accept) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= ar_addr_d;
        ar_len_q   <= ar_len_d;
        ar_burst_q <= ar_burst_d;
        ar_id_q    <= alloc_idx;
      end else if (ar_ready_i) begin
        ar_valid_q <= 1'b0;
      end
    end
  end

  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = ar_addr_q;
  assign ar_len_o   = ar_len_q;
  assign ar_size_o  = 3'(WordOffW);
  assign ar_burst_o = ar_burst_q;
  assign ar_id_o    = ar_id_q;
  assign r_ready_o  = r_ready_q;
  assign r_hs       = r_valid_i & r_ready_q;

  for (genvar s = 0; s < int'(MaxOutstanding); s++) begin : g_slot
    assign alloc_vec[s] = accept && (alloc_idx == AxiIdWidth'(s));
    assign beat_vec[s]  = r_hs && (r_id_i == AxiIdWidth'(s));

    icache_refill_slot #(
      .AxiDataWidth (AxiDataWidth),
      .LineWidth    (LineWidth),
      .TidWidth     (TidWidth)
    ) i_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .alloc_i     (alloc_vec[s]),
      .tid_i       (req_tid_i),
      .nc_i        (req_nc_i),
      .start_i     (start_d),
      .beat_i      (beat_vec[s]),
      .beat_data_i (r_data_i),
      .beat_err_i  (r_resp_i[AXI_RESP_ERR_BIT]),
      .beat_last_i (r_last_i),
      .free_o      (slot_free[s]),
      .done_o      (slot_done[s]),
      .tid_o       (slot_tid[s]),
      .nc_o        (slot_nc[s]),
      .err_o       (slot_err[s]),
      .line_o      (slot_line[s])
    );
  end

  // Only one R beat per cycle, so at most one slot completes per cycle and
  // a plain AND-OR mux is enough.
  always_comb begin
    rtrn_valid_o = 1'b0;
    rtrn_data_o  = '0;
    rtrn_tid_o   = '0;
    rtrn_nc_o    = 1'b0;
    rtrn_err_o   = 1'b0;
    for (int s = 0; s < int'(MaxOutstanding); s++) begin
      if (slot_done[s]) begin
        rtrn_valid_o = 1'b1;
        rtrn_data_o  = rtrn_data_o | slot_line[s];
        rtrn_tid_o   = rtrn_tid_o | slot_tid[s];
        rtrn_nc_o    = rtrn_nc_o | slot_nc[s];
        rtrn_err_o   = rtrn_err_o | slot_err[s];
      end
    end
  end

  assign busy_o = ~(&slot_free) | ar_valid_q;

`ifndef SYNTHESIS
  logic beat_ok;
  assign beat_ok = |(beat_vec & ~slot_free);

  a_beat_to_live_slot: assert property (
    @(posedge clk_i) disable iff (!rst_ni) r_hs |-> beat_ok
  );
`endif

endmodule

// File: tb/tb_icache_axi_refill_bridge.sv
`timescale 1ns/1ps
module tb_icache_axi_refill_bridge;
  localparam int PW = 56, AW = 64, DW = 64, IW = 4, LW = 128, TW = 2, MO = 2;
  localparam int WORDS = LW / DW;
  localparam int WB = DW / 8;
  localparam int LB = LW / 8;

  logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic req_valid_i = 1'b0, req_ready_o, req_nc_i = 1'b0;
  logic [PW-1:0] req_paddr_i = '0;
  logic [TW-1:0] req_tid_i = '0;
  logic rtrn_valid_o, rtrn_nc_o, rtrn_err_o;
  logic [LW-1:0] rtrn_data_o;
  logic [TW-1:0] rtrn_tid_o;
  logic ar_valid_o, ar_ready_i = 1'b1;
  logic [AW-1:0] ar_addr_o;
  logic [7:0] ar_len_o;
  logic [2:0] ar_size_o;
  logic [1:0] ar_burst_o;
  logic [IW-1:0] ar_id_o;
  logic r_valid_i = 1'b0, r_ready_o, r_last_i = 1'b0;
  logic [DW-1:0] r_data_i = '0;
  logic [IW-1:0] r_id_i = '0;
  logic [1:0] r_resp_i = '0;
  logic busy_o;

  always #5 clk_i = ~clk_i;

  icache_axi_refill_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i),
    .req_nc_i(req_nc_i), .req_tid_i(req_tid_i),
    .rtrn_valid_o(rtrn_valid_o), .rtrn_data_o(rtrn_data_o), .rtrn_tid_o(rtrn_tid_o),
    .rtrn_nc_o(rtrn_nc_o), .rtrn_err_o(rtrn_err_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o), .ar_id_o(ar_id_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_id_i(r_id_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i), .busy_o(busy_o)
  );

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy[MO], m_kill[MO], m_nc[MO], m_err[MO];
  int m_tid[MO], m_cnt[MO], m_start[MO];
  logic [DW-1:0] m_line[MO][WORDS];
  bit m_arv;
  longint unsigned m_ar_addr;
  int m_ar_len, m_ar_burst, m_ar_id;
  bit m_rv, m_rnc, m_rerr, m_rready;
  logic [LW-1:0] m_rdata;
  int m_rtid;

  task automatic model_step();
    int a, id;
    bit acc;
    longint unsigned pa;
    if (!rst_ni) begin
      for (int s = 0; s < MO; s++) begin
        m_busy[s] = 0; m_kill[s] = 0; m_nc[s] = 0; m_err[s] = 0;
        m_tid[s] = 0; m_cnt[s] = 0; m_start[s] = 0;
      end
      m_arv = 0; m_rv = 0; m_rready = 0;
      return;
    end
    a = -1;
    for (int s = 0; s < MO; s++) if (!m_busy[s] && a < 0) a = s;
    acc = req_valid_i && (a >= 0) && (!m_arv || ar_ready_i);
    if (m_arv && ar_ready_i) m_arv = 0;
    m_rv = 0;
    if (r_valid_i && m_rready) begin
      id = int'(r_id_i);
      if (id < MO && m_busy[id]) begin
        if (m_cnt[id] < WORDS) begin
          m_line[id][(m_start[id] + m_cnt[id]) % WORDS] = r_data_i;
          m_cnt[id]++;
        end
        if (r_resp_i[1]) m_err[id] = 1;
        if (r_last_i) begin
          m_busy[id] = 0;
          if (!m_kill[id] && !flush_i) begin
            m_rv = 1; m_rtid = m_tid[id]; m_rnc = m_nc[id]; m_rerr = m_err[id];
            for (int w = 0; w < WORDS; w++) m_rdata[w*DW +: DW] = m_line[id][w];
          end
        end
      end
    end
    if (flush_i) for (int s = 0; s < MO; s++) if (m_busy[s]) m_kill[s] = 1;
    if (acc) begin
      pa = 64'(req_paddr_i);
      m_busy[a] = 1; m_kill[a] = 0; m_err[a] = 0; m_cnt[a] = 0;
      m_nc[a] = req_nc_i; m_tid[a] = int'(req_tid_i);
      for (int w = 0; w < WORDS; w++) m_line[a][w] = '0;
      m_arv = 1; m_ar_id = a;
      if (req_nc_i) begin
        m_ar_addr = (pa / WB) * WB; m_ar_len = 0; m_ar_burst = 1; m_start[a] = 0;
      end else begin
`ifdef ICACHE_REFILL_CRIT_WORD_EN
        if (WORDS > 1) begin
          m_ar_addr = (pa / WB) * WB; m_ar_burst = 2; m_start[a] = int'((pa / WB) % WORDS);
        end else begin
          m_ar_addr = (pa / LB) * LB; m_ar_burst = 1; m_start[a] = 0;
        end
`else
        m_ar_addr = (pa / LB) * LB; m_ar_burst = 1; m_start[a] = 0;
`endif
        m_ar_len = WORDS - 1;
      end
    end
    m_rready = 1;
  endtask

  initial forever begin
    @(posedge clk_i);
    model_step();
  end

  // ---------------- per-cycle compare + monitors ----------------
  typedef struct { logic [AW-1:0] addr; logic [7:0] len; logic [1:0] burst; logic [IW-1:0] id; } ar_rec_t;
  typedef struct { logic [LW-1:0] data; logic [TW-1:0] tid; logic nc; logic err; } rt_rec_t;
  ar_rec_t ar_q[$];
  rt_rec_t rt_q[$];

  task automatic compare();
    bit anyf, anyb;
    anyf = 0; anyb = 0;
    for (int s = 0; s < MO; s++) begin
      if (!m_busy[s]) anyf = 1;
      else anyb = 1;
    end
    chk("req_ready", req_ready_o, anyf && (!m_arv || ar_ready_i));
    chk("r_ready", r_ready_o, m_rready);
    chk("busy", busy_o, anyb || m_arv);
    chk("ar_size", ar_size_o, 3);
    chk("ar_valid", ar_valid_o, m_arv);
    if (m_arv) begin
      chk("ar_addr", ar_addr_o, m_ar_addr);
      chk("ar_len", ar_len_o, m_ar_len);
      chk("ar_burst", ar_burst_o, m_ar_burst);
      chk("ar_id", ar_id_o, m_ar_id);
    end
    chk("rtrn_valid", rtrn_valid_o, m_rv);
    if (m_rv) begin
      chk("rtrn_data", rtrn_data_o, m_rdata);
      chk("rtrn_tid", rtrn_tid_o, m_rtid);
      chk("rtrn_nc", rtrn_nc_o, m_rnc);
      chk("rtrn_err", rtrn_err_o, m_rerr);
    end
    if (ar_valid_o && ar_ready_i) ar_q.push_back('{ar_addr_o, ar_len_o, ar_burst_o, ar_id_o});
    if (rtrn_valid_o) rt_q.push_back('{rtrn_data_o, rtrn_tid_o, rtrn_nc_o, rtrn_err_o});
  endtask

  initial forever begin
    @(negedge clk_i);
    if (chk_en) compare();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_req(input string name, input logic [PW-1:0] pa, input logic nc, input logic [TW-1:0] tid);
    bit ok;
    ok = 0;
    req_valid_i = 1; req_paddr_i = pa; req_nc_i = nc; req_tid_i = tid;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk_i);
      ok = req_ready_o;
      tick();
    end
    req_valid_i = 0;
    chk({name, "_accepted"}, ok, 1);
  endtask

  task automatic beat(input int id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
    r_valid_i = 1; r_id_i = IW'(id); r_data_i = d; r_resp_i = resp; r_last_i = last;
    tick();
    r_valid_i = 0; r_last_i = 0;
  endtask

  task automatic expect_ar(input string name, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [IW-1:0] id);
    ar_rec_t r;
    chk({name, "_ar_seen"}, ar_q.size() > 0, 1);
    if (ar_q.size() > 0) begin
      r = ar_q.pop_front();
      chk({name, "_ar_addr"}, r.addr, addr);
      chk({name, "_ar_len"}, r.len, len);
      chk({name, "_ar_burst"}, r.burst, burst);
      chk({name, "_ar_id"}, r.id, id);
    end
  endtask

  task automatic expect_rt(input string name, input logic [LW-1:0] data, input logic [TW-1:0] tid,
                           input logic nc, input logic err);
    rt_rec_t r;
    chk({name, "_rt_seen"}, rt_q.size() > 0, 1);
    if (rt_q.size() > 0) begin
      r = rt_q.pop_front();
      chk({name, "_rt_data"}, r.data, data);
      chk({name, "_rt_tid"}, r.tid, tid);
      chk({name, "_rt_nc"}, r.nc, nc);
      chk({name, "_rt_err"}, r.err, err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_r_ready", r_ready_o, 0);
    chk("rst_ar_valid", ar_valid_o, 0);
    chk("rst_ar_addr", ar_addr_o, 0);
    chk("rst_rtrn_valid", rtrn_valid_o, 0);
    chk("rst_rtrn_data", rtrn_data_o, 0);
    chk("rst_busy", busy_o, 0);
    tick();
    rst_ni = 1; chk_en = 1;
    idle(1);

    // cacheable two-beat refill
    send_req("t1", 56'h8000_1238, 0, 1);
    idle(2);
    beat(0, 64'hA, 2'b00, 0);
    beat(0, 64'hB, 2'b00, 1);
    @(negedge clk_i);
    chk("t1_pulse_after_last", rtrn_valid_o, 1);
    tick(); idle(1);
    expect_ar("t1", 64'h8000_1230, 8'd1, 2'b01, 4'd0);
    expect_rt("t1", {64'hB, 64'hA}, 2'd1, 0, 0);

    // two outstanding, out-of-order return, third request stalls
    send_req("t2a", 56'h100, 0, 0);
    send_req("t2b", 56'h200, 0, 1);
    fork
      send_req("t2c", 56'h300, 0, 2);
      begin
        idle(1);
        beat(1, 64'h11, 2'b00, 0);
        @(negedge clk_i);
        chk("t2_stall_ready", req_ready_o, 0);
        tick();
        beat(1, 64'h12, 2'b00, 1);
        @(negedge clk_i);
        chk("t2_ready_after_free", req_ready_o, 1);
        tick();
        beat(0, 64'h21, 2'b00, 0);
        beat(0, 64'h22, 2'b00, 1);
      end
    join
    idle(2);
    beat(1, 64'h31, 2'b00, 0);
    beat(1, 64'h32, 2'b00, 1);
    idle(2);
    expect_ar("t2a", 64'h100, 8'd1, 2'b01, 4'd0);
    expect_ar("t2b", 64'h200, 8'd1, 2'b01, 4'd1);
    expect_ar("t2c", 64'h300, 8'd1, 2'b01, 4'd1);
    expect_rt("t2_first", {64'h12, 64'h11}, 2'd1, 0, 0);
    expect_rt("t2_second", {64'h22, 64'h21}, 2'd0, 0, 0);
    expect_rt("t2_third", {64'h32, 64'h31}, 2'd2, 0, 0);

    // non-cacheable single beat
    send_req("t3", 56'h1004, 1, 3);
    idle(2);
    beat(0, 64'hDEAD, 2'b00, 1);
    idle(2);
    expect_ar("t3", 64'h1000, 8'd0, 2'b01, 4'd0);
    expect_rt("t3", 128'hDEAD, 2'd3, 1, 0);

    // AR backpressure
    ar_ready_i = 0;
    send_req("t4a", 56'h4000, 0, 0);
    req_valid_i = 1; req_paddr_i = 56'h5008; req_nc_i = 0; req_tid_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t4_stall_ready", req_ready_o, 0);
      chk("t4_stall_ar_valid", ar_valid_o, 1);
      chk("t4_stall_ar_addr", ar_addr_o, 64'h4000);
      tick();
    end
    ar_ready_i = 1;
    @(negedge clk_i);
    chk("t4_ready_on_handshake", req_ready_o, 1);
    tick();
    req_valid_i = 0;
    idle(2);
    beat(0, 64'h41, 2'b00, 0);
    beat(0, 64'h42, 2'b00, 1);
    beat(1, 64'h51, 2'b00, 0);
    beat(1, 64'h52, 2'b00, 1);
    idle(2);
    expect_ar("t4a", 64'h4000, 8'd1, 2'b01, 4'd0);
    expect_ar("t4b", 64'h5000, 8'd1, 2'b01, 4'd1);
    expect_rt("t4a", {64'h42, 64'h41}, 2'd0, 0, 0);
    expect_rt("t4b", {64'h52, 64'h51}, 2'd1, 0, 0);

    // flush kills the waiting refill but not the one accepted in the flush cycle
    send_req("t5a", 56'h6000, 0, 2);
    idle(2);
    flush_i = 1;
    send_req("t5b", 56'h6100, 0, 3);
    flush_i = 0;
    idle(2);
    beat(0, 64'h61, 2'b00, 0);
    beat(0, 64'h62, 2'b00, 1);
    @(negedge clk_i);
    chk("t5_killed_no_pulse", rtrn_valid_o, 0);
    chk("t5_busy_other_live", busy_o, 1);
    tick();
    beat(1, 64'h71, 2'b00, 0);
    beat(1, 64'h72, 2'b00, 1);
    @(negedge clk_i);
    chk("t5_busy_dropped", busy_o, 0);
    tick(); idle(1);
    expect_ar("t5a", 64'h6000, 8'd1, 2'b01, 4'd0);
    expect_ar("t5b", 64'h6100, 8'd1, 2'b01, 4'd1);
    expect_rt("t5b", {64'h72, 64'h71}, 2'd3, 0, 0);
    chk("t5_no_extra_rtrn", rt_q.size(), 0);

    // error response on a live slot
    send_req("t6", 56'h7000, 0, 1);
    idle(2);
    beat(0, 64'h81, 2'b10, 0);
    beat(0, 64'h82, 2'b00, 1);
    idle(2);
    expect_ar("t6", 64'h7000, 8'd1, 2'b01, 4'd0);
    expect_rt("t6", {64'h82, 64'h81}, 2'd1, 0, 1);

`ifdef ICACHE_REFILL_CRIT_WORD_EN
    send_req("t7", 56'h8000_1238, 0, 1);
    idle(2);
    beat(0, 64'hB, 2'b00, 0);
    beat(0, 64'hA, 2'b00, 1);
    idle(2);
    expect_ar("t7", 64'h8000_1238, 8'd1, 2'b10, 4'd0);
    expect_rt("t7", {64'hB, 64'hA}, 2'd1, 0, 0);
`endif

    idle(3);
    chk("end_ar_q_empty", ar_q.size(), 0);
    chk("end_rt_q_empty", rt_q.size(), 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
